// File: rtl/cache_fill_ctrl_if.sv
// Bus between cache_fill_ctrl and its surroundings: request, tag/LRU reads, memory, fill/LRU writes.
// The master side is the pipeline plus arrays plus memory; the slave side is the controller.
interface cache_fill_ctrl_if #(
   parameter int SETS  = 64,
   parameter int WORDS = 8
);
   localparam int IDX_W = $clog2(SETS);
   localparam int OFF_W = $clog2(WORDS);
   localparam int TAG_W = 16 - IDX_W - OFF_W - 1;

   logic              req_valid;
   logic              req_write;
   logic [15:0]       req_addr;
   logic              way0_valid;
   logic              way1_valid;
   logic [TAG_W-1:0]  way0_tag;
   logic [TAG_W-1:0]  way1_tag;
   logic              lru_way0_isLRU;
   logic              mem_data_valid;

   logic              hit;
   logic              hit_way;
   logic              stall;
   logic              mem_en;
   logic [15:0]       mem_addr;
   logic              fill_we;
   logic              fill_way;
   logic [OFF_W-1:0]  fill_word;
   logic              tag_we;
   logic              lru_we;
   logic [SETS-1:0]   lru_set_en;
   logic              lru_block;

   modport master (
      output req_valid, req_write, req_addr,
      output way0_valid, way1_valid, way0_tag, way1_tag, lru_way0_isLRU,
      output mem_data_valid,
      input  hit, hit_way, stall, mem_en, mem_addr,
      input  fill_we, fill_way, fill_word, tag_we,
      input  lru_we, lru_set_en, lru_block
   );

   modport slave (
      input  req_valid, req_write, req_addr,
      input  way0_valid, way1_valid, way0_tag, way1_tag, lru_way0_isLRU,
      input  mem_data_valid,
      output hit, hit_way, stall, mem_en, mem_addr,
      output fill_we, fill_way, fill_word, tag_we,
      output lru_we, lru_set_en, lru_block
   );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Hit/miss and block-fill controller for a 2-way set-associative cache with per-set LRU.
// Define CACHE_WRITE_ALLOC_EN to make store misses allocate; otherwise they bypass the cache.
module cache_fill_ctrl #(
   parameter int SETS  = 64,
   parameter int WORDS = 8
) (
   input  logic             clk,
   input  logic             rst,
   cache_fill_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int OFF_W = $clog2(WORDS);
   localparam int TAG_W = 16 - IDX_W - OFF_W - 1;

`ifdef CACHE_WRITE_ALLOC_EN
   localparam bit WRITE_ALLOC = 1'b1;
`else
   localparam bit WRITE_ALLOC = 1'b0;
`endif

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state;
   state_t            state_next;
   logic [TAG_W-1:0]  lat_tag;
   logic [IDX_W-1:0]  lat_index;
   logic              victim;
   logic [OFF_W-1:0]  issue_cnt;
   logic              issue_done;
   logic [OFF_W-1:0]  recv_cnt;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_index;
   logic              hit0;
   logic              hit1;
   logic              any_hit;
   logic              hit_way_sel;
   logic              allocate;
   logic              victim_sel;
   logic              issue_last;
   logic              recv_last;
   logic              start_fill;
   logic              unused_addr_bits;

   logic              hit_o;
   logic              hit_way_o;
   logic              stall_o;
   logic              mem_en_o;
   logic [15:0]       mem_addr_o;
   logic              fill_we_o;
   logic              fill_way_o;
   logic [OFF_W-1:0]  fill_word_o;
   logic              tag_we_o;
   logic              lru_we_o;
   logic [SETS-1:0]   lru_set_en_o;
   logic              lru_block_o;

   assign req_tag          = bus.req_addr[15 -: TAG_W];
   assign req_index        = bus.req_addr[OFF_W+1 +: IDX_W];
   assign unused_addr_bits = ^bus.req_addr[OFF_W:0];

   // Way 0 takes priority when both ways report a match.
   assign hit0        = bus.way0_valid && (bus.way0_tag == req_tag);
   assign hit1        = bus.way1_valid && (bus.way1_tag == req_tag);
   assign any_hit     = hit0 || hit1;
   assign hit_way_sel = !hit0;
   assign allocate    = !bus.req_write || WRITE_ALLOC;

   // Prefer an empty way; only consult LRU when the set is full.
   assign victim_sel  = !bus.way0_valid ? 1'b0 :
                        !bus.way1_valid ? 1'b1 :
                        (bus.lru_way0_isLRU ? 1'b0 : 1'b1);

   assign issue_last  = (issue_cnt == OFF_W'(WORDS - 1));
   assign recv_last   = (recv_cnt  == OFF_W'(WORDS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lat_tag    <= '0;
         lat_index  <= '0;
         victim     <= 1'b0;
         issue_cnt  <= '0;
         issue_done <= 1'b0;
         recv_cnt   <= '0;
      end else begin
         state <= state_next;
         if (start_fill) begin
            lat_tag    <= req_tag;
            lat_index  <= req_index;
            victim     <= victim_sel;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            recv_cnt   <= '0;
         end else if (state == FILL) begin
            if (!issue_done) begin
               if (issue_last) begin
                  issue_done <= 1'b1;
               end else begin
                  issue_cnt <= issue_cnt + OFF_W'(1);
               end
            end
            if (bus.mem_data_valid && !recv_last) begin
               recv_cnt <= recv_cnt + OFF_W'(1);
            end
         end
      end
   end

   // Outputs are held at zero for as long as reset is asserted.
   always_comb begin
      state_next   = state;
      start_fill   = 1'b0;
      hit_o        = 1'b0;
      hit_way_o    = 1'b0;
      stall_o      = 1'b0;
      mem_en_o     = 1'b0;
      mem_addr_o   = '0;
      fill_we_o    = 1'b0;
      fill_way_o   = 1'b0;
      fill_word_o  = '0;
      tag_we_o     = 1'b0;
      lru_we_o     = 1'b0;
      lru_set_en_o = '0;
      lru_block_o  = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (any_hit) begin
                     hit_o        = 1'b1;
                     hit_way_o    = hit_way_sel;
                     lru_we_o     = 1'b1;
                     lru_set_en_o = SETS'(1) << req_index;
                     lru_block_o  = ~hit_way_sel;
                  end else if (allocate) begin
                     stall_o    = 1'b1;
                     start_fill = 1'b1;
                     state_next = FILL;
                  end
               end
            end
            FILL: begin
               stall_o = 1'b1;
               if (!issue_done) begin
                  mem_en_o   = 1'b1;
                  mem_addr_o = {lat_tag, lat_index, issue_cnt, 1'b0};
               end
               if (bus.mem_data_valid) begin
                  fill_we_o   = 1'b1;
                  fill_way_o  = victim;
                  fill_word_o = recv_cnt;
                  // Last word: install the tag and mark the other way LRU.
                  if (recv_last) begin
                     tag_we_o     = 1'b1;
                     lru_we_o     = 1'b1;
                     lru_set_en_o = SETS'(1) << lat_index;
                     lru_block_o  = ~victim;
                     state_next   = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign bus.hit        = hit_o;
   assign bus.hit_way    = hit_way_o;
   assign bus.stall      = stall_o;
   assign bus.mem_en     = mem_en_o;
   assign bus.mem_addr   = mem_addr_o;
   assign bus.fill_we    = fill_we_o;
   assign bus.fill_way   = fill_way_o;
   assign bus.fill_word  = fill_word_o;
   assign bus.tag_we     = tag_we_o;
   assign bus.lru_we     = lru_we_o;
   assign bus.lru_set_en = lru_set_en_o;
   assign bus.lru_block  = lru_block_o;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: ideal tag/LRU arrays, a 3-cycle pipelined memory, and a
// transaction-level model checked against the DUT on every negative clock edge.
module tb_cache_fill_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

`ifdef CACHE_WRITE_ALLOC_EN
   localparam bit ALLOC = 1'b1;
`else
   localparam bit ALLOC = 1'b0;
`endif

   cache_fill_ctrl_if #(.SETS(64), .WORDS(8)) bus ();
   cache_fill_ctrl #(.SETS(64), .WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic       arr_valid [64][2];
   logic [5:0] arr_tag   [64][2];
   logic       arr_lru   [64];
   logic [2:0] mem_pipe;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model: a fill is a count of cycles since the miss plus a count of words received.
   initial begin
      bit          m_fill;
      logic [5:0]  m_tag, m_idx, tg, ix;
      logic        m_victim, h0, h1;
      int          m_age, m_recv;
      logic        e_hit, e_hit_way, e_stall, e_mem_en, e_fill_we, e_fill_way, e_tag_we, e_lru_we, e_lru_block;
      logic [15:0] e_mem_addr;
      logic [2:0]  e_fill_word;
      logic [63:0] e_set_en;
      for (int s = 0; s < 64; s++) begin
         arr_valid[s][0] = 1'b0;
         arr_valid[s][1] = 1'b0;
         arr_tag[s][0]   = 6'd0;
         arr_tag[s][1]   = 6'd0;
         arr_lru[s]      = 1'b0;
      end
      m_fill = 0; m_tag = 0; m_idx = 0; m_victim = 0; m_age = 0; m_recv = 0;
      forever begin
         @(negedge clk);
         e_hit = 0; e_hit_way = 0; e_stall = 0; e_mem_en = 0; e_mem_addr = 0; e_fill_we = 0;
         e_fill_way = 0; e_fill_word = 0; e_tag_we = 0; e_lru_we = 0; e_set_en = 0; e_lru_block = 0;
         if (rst) begin
            m_fill = 0;
         end else if (!m_fill) begin
            if (bus.req_valid) begin
               tg = bus.req_addr[15:10];
               ix = bus.req_addr[9:4];
               h0 = bus.way0_valid && (bus.way0_tag == tg);
               h1 = bus.way1_valid && (bus.way1_tag == tg);
               if (h0 || h1) begin
                  e_hit = 1; e_hit_way = !h0; e_lru_we = 1;
                  e_set_en = 64'd1 << ix; e_lru_block = h0;
                  arr_lru[ix] = h0;
               end else if (!bus.req_write || ALLOC) begin
                  e_stall = 1;
                  m_fill = 1; m_tag = tg; m_idx = ix; m_age = 0; m_recv = 0;
                  if (!bus.way0_valid)      m_victim = 0;
                  else if (!bus.way1_valid) m_victim = 1;
                  else                      m_victim = bus.lru_way0_isLRU ? 1'b0 : 1'b1;
               end
            end
         end else begin
            m_age++;
            e_stall = 1;
            if (m_age <= 8) begin
               e_mem_en = 1;
               e_mem_addr = {m_tag, m_idx, 3'(m_age - 1), 1'b0};
            end
            if (bus.mem_data_valid) begin
               e_fill_we = 1; e_fill_way = m_victim; e_fill_word = 3'(m_recv);
               m_recv++;
               if (m_recv == 8) begin
                  e_tag_we = 1; e_lru_we = 1; e_set_en = 64'd1 << m_idx; e_lru_block = !m_victim;
                  arr_valid[m_idx][m_victim] = 1'b1;
                  arr_tag[m_idx][m_victim]   = m_tag;
                  arr_lru[m_idx]             = !m_victim;
                  m_fill = 0;
               end
            end
         end
         checkOutput("hit", bus.hit, e_hit);
         checkOutput("stall", bus.stall, e_stall);
         checkOutput("mem_en", bus.mem_en, e_mem_en);
         checkOutput("fill_we", bus.fill_we, e_fill_we);
         checkOutput("tag_we", bus.tag_we, e_tag_we);
         checkOutput("lru_we", bus.lru_we, e_lru_we);
         if (e_hit) checkOutput("hit_way", bus.hit_way, e_hit_way);
         if (e_mem_en) checkOutput("mem_addr", bus.mem_addr, e_mem_addr);
         if (e_fill_we) begin
            checkOutput("fill_way", bus.fill_way, e_fill_way);
            checkOutput("fill_word", bus.fill_word, e_fill_word);
         end
         if (e_lru_we || rst) begin
            checkOutput("lru_set_en", bus.lru_set_en, e_set_en);
            checkOutput("lru_block", bus.lru_block, e_lru_block);
         end
         if (rst) begin
            checkOutput("rst hit_way", bus.hit_way, 0);
            checkOutput("rst mem_addr", bus.mem_addr, 0);
            checkOutput("rst fill_way", bus.fill_way, 0);
            checkOutput("rst fill_word", bus.fill_word, 0);
         end
      end
   end

   task automatic refreshArrays();
      logic [5:0] ix;
      ix = bus.req_addr[9:4];
      bus.way0_valid     = arr_valid[ix][0];
      bus.way1_valid     = arr_valid[ix][1];
      bus.way0_tag       = arr_tag[ix][0];
      bus.way1_tag       = arr_tag[ix][1];
      bus.lru_way0_isLRU = (arr_lru[ix] == 1'b0);
   endtask

   task automatic applyStimulus(input logic v, input logic w, input logic [15:0] a);
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      refreshArrays();
   endtask

   task automatic sampleEdge();
      @(negedge clk);
      mem_pipe = {mem_pipe[1:0], bus.mem_en};
   endtask

   task automatic nextCycle(input logic extra_mdv);
      @(posedge clk);
      #1;
      bus.mem_data_valid = mem_pipe[2] | extra_mdv;
      refreshArrays();
   endtask

   // Miss, full 8-word fill, replay hit in cycle 12; optional stray data pulse in cycle 12.
   task automatic runFill(input logic w, input logic [15:0] a, input logic vic, input logic late_pulse);
      applyStimulus(1'b1, w, a);
      for (int c = 0; c <= 12; c++) begin
         sampleEdge();
         if (c == 0) checkOutput("miss stall", bus.stall, 1);
         if (c == 1) checkOutput("first mem_addr", bus.mem_addr, {a[15:4], 4'h0});
         if (c == 8) checkOutput("last mem_addr", bus.mem_addr, {a[15:4], 4'hE});
         if (c == 9) checkOutput("issue stops", bus.mem_en, 0);
         if (c == 4) begin
            checkOutput("first fill_word", bus.fill_word, 0);
            checkOutput("first fill_way", bus.fill_way, vic);
         end
         if (c == 11) begin
            checkOutput("final tag_we", bus.tag_we, 1);
            checkOutput("final fill_word", bus.fill_word, 7);
            checkOutput("final lru_block", bus.lru_block, !vic);
         end
         if (c == 12) begin
            checkOutput("replay hit", bus.hit, 1);
            checkOutput("replay hit_way", bus.hit_way, vic);
            checkOutput("replay stall", bus.stall, 0);
            if (late_pulse) checkOutput("ninth pulse fill_we", bus.fill_we, 0);
         end
         nextCycle((c == 11) && late_pulse);
      end
      applyStimulus(1'b0, 1'b0, a);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      mem_pipe = 3'b000;
      bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0;
      bus.way0_valid = 0; bus.way1_valid = 0; bus.way0_tag = 0; bus.way1_tag = 0;
      bus.lru_way0_isLRU = 0; bus.mem_data_valid = 0;
      @(posedge clk); #1;
      refreshArrays();

      sampleEdge();
      checkOutput("reset stall", bus.stall, 0);
      checkOutput("reset lru_set_en", bus.lru_set_en, 0);
      nextCycle(1'b0);
      rst = 1'b0;

      runFill(1'b0, 16'h1230, 1'b0, 1'b0);

      runFill(1'b0, 16'hA850, 1'b0, 1'b0);
      runFill(1'b0, 16'h4450, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h4450);
      sampleEdge();
      checkOutput("way1 hit", bus.hit, 1);
      checkOutput("way1 hit_way", bus.hit_way, 1);
      checkOutput("way1 lru_we", bus.lru_we, 1);
      checkOutput("way1 lru_set_en", bus.lru_set_en, 64'h20);
      checkOutput("way1 lru_block", bus.lru_block, 0);
      checkOutput("way1 stall", bus.stall, 0);
      nextCycle(1'b0);

      runFill(1'b0, 16'hCC50, 1'b0, 1'b0);

      applyStimulus(1'b1, 1'b0, 16'h0870);
      for (int c = 0; c <= 6; c++) begin
         sampleEdge();
         nextCycle(1'b0);
      end
      rst = 1'b1;
      mem_pipe = 3'b000;
      bus.mem_data_valid = 1'b0;
      sampleEdge();
      checkOutput("mid-fill rst stall", bus.stall, 0);
      checkOutput("mid-fill rst tag_we", bus.tag_we, 0);
      checkOutput("mid-fill rst mem_en", bus.mem_en, 0);
      checkOutput("mid-fill rst fill_we", bus.fill_we, 0);
      nextCycle(1'b0);
      rst = 1'b0;
      runFill(1'b0, 16'h0870, 1'b0, 1'b0);

`ifdef CACHE_WRITE_ALLOC_EN
      runFill(1'b1, 16'h4000, 1'b0, 1'b0);
`else
      applyStimulus(1'b1, 1'b1, 16'h4000);
      for (int c = 0; c < 2; c++) begin
         sampleEdge();
         checkOutput("write miss stall", bus.stall, 0);
         checkOutput("write miss mem_en", bus.mem_en, 0);
         checkOutput("write miss lru_we", bus.lru_we, 0);
         nextCycle(1'b0);
      end
      applyStimulus(1'b0, 1'b0, 16'h4000);
`endif

      nextCycle(1'b1);
      sampleEdge();
      checkOutput("idle pulse fill_we", bus.fill_we, 0);
      checkOutput("idle stall", bus.stall, 0);
      nextCycle(1'b0);
      runFill(1'b0, 16'h0C90, 1'b0, 1'b1);

      sampleEdge();
      nextCycle(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
